onchip_mem_rr_arbiter: RTL and testbench
========================================

Name: onchip_mem_rr_arbiter

Overview:
- Two-port round-robin arbiter that shares the single-port 32-bit on-chip RAM (5120 words, 13-bit word address, 4 byte lanes) between two Avalon-MM masters (e.g. CPU data master and a DMA).
- Sits between the masters and the RAM slave.
- Adds waitrequest/readdatavalid handshaking and an out-of-range address guard.
- Matches the RAM's one-cycle read latency.

Parameters:
- ADDR_W, 13, word address width.
- DEPTH, 5120, number of valid words; addresses >= DEPTH are out of range.
- OOR_RDATA, 32'h0000_0000, read data returned for out-of-range reads.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- m0_address / m1_address  in  ADDR_W  requester word address.
- m0_read / m1_read  in  1  read request.
- m0_write / m1_write  in  1  write request.
- m0_byteenable / m1_byteenable  in  4  byte lanes.
- m0_writedata / m1_writedata  in  32  write data.
- m0_waitrequest / m1_waitrequest  out  1  request not accepted this cycle.
- m0_readdata / m1_readdata  out  32  read data.
- m0_readdatavalid / m1_readdatavalid  out  1  readdata valid this cycle.
- m0_oor_err / m1_oor_err  out  1  sticky out-of-range flag.
- m0_err_clr / m1_err_clr  in  1  clears the corresponding sticky flag.
- mem_address  out  ADDR_W  to RAM.
- mem_byteenable  out  4  to RAM.
- mem_chipselect  out  1  to RAM.
- mem_write  out  1  to RAM.
- mem_writedata  out  32  to RAM.
- mem_clken  out  1  to RAM; tied 1.
- mem_readdata  in  32  from RAM; valid 1 cycle after the address.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Request definition: req_n = mN_read | mN_write. Read and write asserted together is treated as a write.
- Grant (combinational):
  - Only one requester: it is granted.
  - Both requesting: the port not granted most recently wins.
  - last_grant updates on every granted cycle.
  - Reset value of last_grant = 1, so m0 wins the first contention.
- Waitrequest:
  - mN_waitrequest = req_n & ~grant_n.
  - Idle ports see waitrequest 0.
  - While reset is asserted, both waitrequests = 1.
- Mux: the granted port's address, byteenable and writedata drive mem_*.
  - With no grant, mem_* hold the last granted values; mem_chipselect = 0, mem_write = 0.
- Range check: in_range = (address < DEPTH).
  - mem_chipselect = grant & in_range.
  - mem_write = grant & write & in_range.
  - Out-of-range writes are dropped and never reach the RAM.
- Read pipeline (registered, one stage): rd_v, rd_owner, rd_oor are captured on a granted read.
  - Next cycle: mOwner_readdatavalid = 1.
  - readdata = rd_oor ? OOR_RDATA : mem_readdata.
  - Non-owner readdata holds its previous value.
  - Back-to-back reads complete at one per cycle; latency is exactly 1 cycle after acceptance.
- Writes: complete in the grant cycle; there is no response phase.
- Error flag:
  - mN_oor_err is set on any accepted out-of-range access.
  - mN_err_clr clears it; set wins if both occur in the same cycle.
- Reset values: all readdatavalid = 0, readdata = 0, oor_err = 0, rd_v = 0, mem_chipselect = 0, mem_write = 0, mem_address = 0.
- Reset mid-read: the pending readdatavalid is dropped and no response is issued. After release, arbitration restarts with m0 priority.
- Fairness: under continuous requests from both ports, grants alternate strictly: m0, m1, m0, ...

Optional Feature:
- Macro: ONCHIP_ARB_STALL_CNT_EN.
- When defined:
  - Adds outputs m0_stall_cnt and m1_stall_cnt (16 bits each).
  - Each counts cycles with mN_waitrequest = 1, saturates at 16'hFFFF, resets to 0.
  - Each is cleared by the corresponding mN_err_clr.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single master: m0 writes 32'hA5A5_1234 to addr 10 with be 4'hF, then reads addr 10. Required: waitrequest 0 both cycles; readdatavalid on cycle+1 with readdata 32'hA5A5_1234; m1_readdatavalid stays 0.
- Contention: m0 and m1 both read continuously for 6 cycles. Required: grants m0, m1, m0, m1, m0, m1; each port sees waitrequest 1 on alternate cycles; 3 readdatavalid pulses per port, each routed to the correct owner.
- Byte enables: write 32'hFFFF_FFFF to addr 5, then m1 writes 32'h0000_0000 with be 4'b0101, then read addr 5. Required: 32'hFF00_FF00.
- Out of range: m1 writes addr 5120, then reads addr 8191. Required: mem_chipselect 0 on both; read returns 32'h0; m1_oor_err = 1 until m1_err_clr; RAM contents unchanged.
- Reset mid-read: assert reset in the cycle after a granted m0 read. Required: no readdatavalid; waitrequests = 1 during reset; after release, simultaneous m0/m1 requests grant m0 first.
- With ONCHIP_ARB_STALL_CNT_EN defined: m1 stalled 3 cycles by m0 contention. Required: m1_stall_cnt = 3, m0_stall_cnt unchanged by those cycles; m1_err_clr returns it to 0.

Source files
------------

// File: rtl/onchip_mem_rr_arbiter.sv
// Two-master round-robin arbiter in front of the single-port on-chip RAM, with an
// out-of-range guard and a one-cycle read return path. Optional: ONCHIP_ARB_STALL_CNT_EN.
module onchip_mem_rr_arbiter #(
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned DEPTH     = 5120,
    parameter logic [31:0] OOR_RDATA = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [3:0]        m0_byteenable,
    input  logic [31:0]       m0_writedata,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,
    output logic              m0_oor_err,
    input  logic              m0_err_clr,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [3:0]        m1_byteenable,
    input  logic [31:0]       m1_writedata,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
    output logic              m1_oor_err,
    input  logic              m1_err_clr,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    input  logic [31:0]       mem_readdata
`ifdef ONCHIP_ARB_STALL_CNT_EN
    ,
    output logic [15:0]       m0_stall_cnt,
    output logic [15:0]       m1_stall_cnt
`endif
);

    logic              w_req0, w_req1, w_gnt0, w_gnt1, w_any;
    logic              w_inr0, w_inr1, w_sel_inr, w_sel_wr;
    logic [31:0]       w_rdata;
    logic              r_last;      // 1: m1 was granted most recently
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_be;
    logic [31:0]       r_wd;
    logic              r_rd_v, r_rd_owner, r_rd_oor;
    logic [31:0]       r_rdata0, r_rdata1;
    logic              r_err0, r_err1;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;
    // Grants are suppressed during reset so nothing reaches the RAM.
    assign w_gnt0 = ~reset & w_req0 & (~w_req1 | r_last);
    assign w_gnt1 = ~reset & w_req1 & (~w_req0 | ~r_last);
    assign w_any  = w_gnt0 | w_gnt1;

    assign w_inr0    = 32'(m0_address) < DEPTH;
    assign w_inr1    = 32'(m1_address) < DEPTH;
    assign w_sel_inr = w_gnt0 ? w_inr0   : w_inr1;
    assign w_sel_wr  = w_gnt0 ? m0_write : m1_write;

    assign m0_waitrequest = reset | (w_req0 & ~w_gnt0);
    assign m1_waitrequest = reset | (w_req1 & ~w_gnt1);

    assign mem_address    = w_gnt0 ? m0_address    : (w_gnt1 ? m1_address    : r_addr);
    assign mem_byteenable = w_gnt0 ? m0_byteenable : (w_gnt1 ? m1_byteenable : r_be);
    assign mem_writedata  = w_gnt0 ? m0_writedata  : (w_gnt1 ? m1_writedata  : r_wd);
    assign mem_chipselect = w_any & w_sel_inr;
    assign mem_write      = w_any & w_sel_wr & w_sel_inr;
    assign mem_clken      = 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last     <= 1'b1;
            r_addr     <= '0;
            r_be       <= '0;
            r_wd       <= '0;
            r_rd_v     <= 1'b0;
            r_rd_owner <= 1'b0;
            r_rd_oor   <= 1'b0;
        end else begin
            r_rd_v <= w_any & ~w_sel_wr;
            if (w_any) begin
                r_last     <= w_gnt1;
                r_addr     <= mem_address;
                r_be       <= mem_byteenable;
                r_wd       <= mem_writedata;
                r_rd_owner <= w_gnt1;
                r_rd_oor   <= ~w_sel_inr;
            end
        end
    end

    assign w_rdata          = r_rd_oor ? OOR_RDATA : mem_readdata;
    assign m0_readdatavalid = r_rd_v & ~r_rd_owner;
    assign m1_readdatavalid = r_rd_v &  r_rd_owner;
    // The non-owning port keeps showing whatever it last received.
    assign m0_readdata      = m0_readdatavalid ? w_rdata : r_rdata0;
    assign m1_readdata      = m1_readdatavalid ? w_rdata : r_rdata1;
    assign m0_oor_err       = r_err0;
    assign m1_oor_err       = r_err1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
        end else begin
            if (m0_readdatavalid) r_rdata0 <= w_rdata;
            if (m1_readdatavalid) r_rdata1 <= w_rdata;
            r_err0 <= (w_gnt0 & ~w_inr0) | (r_err0 & ~m0_err_clr);
            r_err1 <= (w_gnt1 & ~w_inr1) | (r_err1 & ~m1_err_clr);
        end
    end

`ifdef ONCHIP_ARB_STALL_CNT_EN
    logic [15:0] r_stall0, r_stall1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall0 <= '0;
            r_stall1 <= '0;
        end else begin
            if (m0_err_clr)                                   r_stall0 <= '0;
            else if (m0_waitrequest && r_stall0 != 16'hFFFF) r_stall0 <= r_stall0 + 16'd1;
            if (m1_err_clr)                                   r_stall1 <= '0;
            else if (m1_waitrequest && r_stall1 != 16'hFFFF) r_stall1 <= r_stall1 + 16'd1;
        end
    end

    assign m0_stall_cnt = r_stall0;
    assign m1_stall_cnt = r_stall1;
`else
    // Stall counters not built.
`endif

endmodule

// File: tb/tb_onchip_mem_rr_arbiter.sv
// Bench for onchip_mem_rr_arbiter: behavioural RAM slave, directed scenarios, then
// random traffic, all checked against a transaction-level reference model.
module tb_onchip_mem_rr_arbiter;
    localparam int          AW    = 13;
    localparam int          DEPTH = 5120;
    localparam logic [31:0] OOR   = 32'h0000_0000;

    typedef struct packed {
        logic          rd;
        logic          wr;
        logic          clr;
        logic [AW-1:0] a;
        logic [3:0]    be;
        logic [31:0]   d;
    } req_t;

    logic clk = 1'b0, reset = 1'b1, fill = 1'b1;
    logic [AW-1:0] m0_address, m1_address, mem_address;
    logic m0_read, m0_write, m0_err_clr, m1_read, m1_write, m1_err_clr;
    logic [3:0] m0_byteenable, m1_byteenable, mem_byteenable;
    logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata, mem_writedata;
    logic [31:0] mem_readdata = '0;
    logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic m0_oor_err, m1_oor_err, mem_chipselect, mem_write, mem_clken;
`ifdef ONCHIP_ARB_STALL_CNT_EN
    logic [15:0] m0_stall_cnt, m1_stall_cnt;
`endif

    onchip_mem_rr_arbiter #(.ADDR_W(AW), .DEPTH(DEPTH), .OOR_RDATA(OOR)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid), .m0_oor_err(m0_oor_err), .m0_err_clr(m0_err_clr),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid), .m1_oor_err(m1_oor_err), .m1_err_clr(m1_err_clr),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
`ifdef ONCHIP_ARB_STALL_CNT_EN
        , .m0_stall_cnt(m0_stall_cnt), .m1_stall_cnt(m1_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(int i);
        return 32'(i) * 32'h9E37_79B1;
    endfunction

    // RAM slave: one-cycle registered read, byte-lane writes.
    logic [31:0] ram [DEPTH];
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < DEPTH; i++) ram[i] <= pat(i);
        end else if (mem_chipselect && int'(mem_address) < DEPTH) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Reference model state
    logic [31:0] gmem [DEPTH];
    int          last;
    bit          pv;
    int          pown;
    logic [31:0] pdata;
    logic [31:0] hold_rd [2];
    bit          err [2];
    int          stall [2];
    logic [AW-1:0] hold_a;
    logic [3:0]    hold_be;
    logic [31:0]   hold_d;

    function automatic req_t RD(int a);
        req_t q = '0;
        q.rd = 1'b1; q.a = AW'(a);
        return q;
    endfunction

    function automatic req_t WR(int a, logic [31:0] d, logic [3:0] be);
        req_t q = '0;
        q.wr = 1'b1; q.a = AW'(a); q.d = d; q.be = be;
        return q;
    endfunction

    function automatic req_t CLR();
        req_t q = '0;
        q.clr = 1'b1;
        return q;
    endfunction

    task automatic drive(input req_t q0, input req_t q1);
        m0_read = q0.rd; m0_write = q0.wr; m0_err_clr = q0.clr; m0_address = q0.a;
        m0_byteenable = q0.be; m0_writedata = q0.d;
        m1_read = q1.rd; m1_write = q1.wr; m1_err_clr = q1.clr; m1_address = q1.a;
        m1_byteenable = q1.be; m1_writedata = q1.d;
    endtask

    task automatic model_reset();
        last = 1; pv = 0; pown = 0; pdata = '0;
        hold_rd[0] = '0; hold_rd[1] = '0; err[0] = 0; err[1] = 0;
        stall[0] = 0; stall[1] = 0; hold_a = '0; hold_be = '0; hold_d = '0;
    endtask

    // One bus cycle: drive, compare everything visible, then advance the model.
    task automatic cyc(input req_t q0, input req_t q1);
        req_t q [2];
        bit rq [2], inr [2], ew [2], ev [2];
        logic gw [2], gv [2], ge [2];
        logic [31:0] gd [2];
        logic [15:0] gs [2];
        int win;
        q[0] = q0; q[1] = q1;
        @(negedge clk);
        drive(q0, q1);
        #1;
        gw[0] = m0_waitrequest;   gw[1] = m1_waitrequest;
        gv[0] = m0_readdatavalid; gv[1] = m1_readdatavalid;
        gd[0] = m0_readdata;      gd[1] = m1_readdata;
        ge[0] = m0_oor_err;       ge[1] = m1_oor_err;
`ifdef ONCHIP_ARB_STALL_CNT_EN
        gs[0] = m0_stall_cnt;     gs[1] = m1_stall_cnt;
`else
        gs[0] = '0;               gs[1] = '0;
`endif
        for (int n = 0; n < 2; n++) begin
            rq[n]  = q[n].rd | q[n].wr;
            inr[n] = int'(q[n].a) < DEPTH;
        end
        if (rq[0] && rq[1]) win = (last == 0) ? 1 : 0;
        else if (rq[0])     win = 0;
        else if (rq[1])     win = 1;
        else                win = -1;
        for (int n = 0; n < 2; n++) begin
            ew[n] = rq[n] && (win != n);
            ev[n] = pv && (pown == n);
            chk($sformatf("m%0d_waitrequest", n), 32'(gw[n]), 32'(ew[n]));
            chk($sformatf("m%0d_readdatavalid", n), 32'(gv[n]), 32'(ev[n]));
            chk($sformatf("m%0d_readdata", n), gd[n], ev[n] ? pdata : hold_rd[n]);
            chk($sformatf("m%0d_oor_err", n), 32'(ge[n]), 32'(err[n]));
`ifdef ONCHIP_ARB_STALL_CNT_EN
            chk($sformatf("m%0d_stall_cnt", n), 32'(gs[n]), 32'(stall[n]));
`endif
        end
        if (win >= 0) begin
            hold_a = q[win].a; hold_be = q[win].be; hold_d = q[win].d;
            chk("mem_chipselect", 32'(mem_chipselect), 32'(inr[win]));
            chk("mem_write", 32'(mem_write), 32'(inr[win] && q[win].wr));
        end else begin
            chk("mem_chipselect", 32'(mem_chipselect), 32'd0);
            chk("mem_write", 32'(mem_write), 32'd0);
        end
        chk("mem_address", 32'(mem_address), 32'(hold_a));
        chk("mem_byteenable", 32'(mem_byteenable), 32'(hold_be));
        chk("mem_writedata", mem_writedata, hold_d);
        // advance to the state after the coming rising edge
        for (int n = 0; n < 2; n++) begin
            if (ev[n]) hold_rd[n] = pdata;
            err[n] = (win == n && !inr[n]) || (err[n] && !q[n].clr);
            if (q[n].clr)                     stall[n] = 0;
            else if (ew[n] && stall[n] < 65535) stall[n]++;
        end
        pv = 0;
        if (win >= 0) begin
            last = win;
            if (q[win].wr) begin
                if (inr[win])
                    for (int b = 0; b < 4; b++)
                        if (q[win].be[b]) gmem[q[win].a][8*b +: 8] = q[win].d[8*b +: 8];
            end else begin
                pv = 1; pown = win;
                pdata = inr[win] ? gmem[q[win].a] : OOR;
            end
        end
    endtask

    task automatic do_reset(input bit hold_req);
        @(negedge clk);
        reset = 1'b1;
        if (hold_req) drive(RD(7), RD(8));
        #1;
        chk("rst_m0_waitrequest", 32'(m0_waitrequest), 32'd1);
        chk("rst_m1_waitrequest", 32'(m1_waitrequest), 32'd1);
        chk("rst_rdv", 32'({m0_readdatavalid, m1_readdatavalid}), 32'd0);
        chk("rst_rdata0", m0_readdata, 32'd0);
        chk("rst_rdata1", m1_readdata, 32'd0);
        chk("rst_err", 32'({m0_oor_err, m1_oor_err}), 32'd0);
        chk("rst_mem_cs", 32'({mem_chipselect, mem_write}), 32'd0);
        chk("rst_mem_address", 32'(mem_address), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        drive('0, '0);
        reset = 1'b0;
    endtask

    initial begin
        req_t z, r0, r1;
        z = '0;
        drive(z, z);
        for (int i = 0; i < DEPTH; i++) gmem[i] = pat(i);
        repeat (2) @(negedge clk);
        fill = 1'b0;
        do_reset(1'b0);
        chk("mem_clken", 32'(mem_clken), 32'd1);

        // single master write then read-back
        cyc(WR(10, 32'hA5A5_1234, 4'hF), z);
        cyc(RD(10), z);
        cyc(z, z);
        chk("single_rdback", m0_readdata, 32'hA5A5_1234);

        // continuous contention from reset: strict alternation starting at m0
        do_reset(1'b0);
        repeat (6) cyc(RD(1), RD(2));
        cyc(z, z);
`ifdef ONCHIP_ARB_STALL_CNT_EN
        chk("contend_m1_stall", 32'(m1_stall_cnt), 32'd3);
        cyc(z, CLR());
        cyc(z, z);
        chk("clr_m1_stall", 32'(m1_stall_cnt), 32'd0);
`endif

        // byte enables
        cyc(WR(5, 32'hFFFF_FFFF, 4'hF), z);
        cyc(z, WR(5, 32'h0000_0000, 4'b0101));
        cyc(RD(5), z);
        cyc(z, z);
        chk("be_rdback", m0_readdata, 32'hFF00_FF00);

        // out of range write and read
        cyc(z, WR(5120, 32'hDEAD_BEEF, 4'hF));
        cyc(z, RD(8191));
        cyc(z, z);
        chk("oor_err_set", 32'(m1_oor_err), 32'd1);
        chk("oor_rdata", m1_readdata, OOR);
        cyc(z, CLR());
        cyc(z, z);
        chk("oor_err_clr", 32'(m1_oor_err), 32'd0);

        // reset one cycle after a granted read
        cyc(RD(3), z);
        do_reset(1'b1);
        cyc(RD(4), RD(6));
        cyc(RD(4), RD(6));
        cyc(z, z);

        // random traffic
        for (int k = 0; k < 400; k++) begin
            for (int n = 0; n < 2; n++) begin
                req_t q;
                int r;
                q = '0;
                r = int'($urandom_range(0, 9));
                q.rd  = (r < 4) || (r == 8);
                q.wr  = (r >= 4 && r < 8) || (r == 8);
                q.a   = ($urandom_range(0, 19) == 0) ? AW'(DEPTH + int'($urandom_range(0, 3071)))
                                                     : AW'($urandom_range(0, 15));
                q.be  = 4'($urandom);
                q.d   = $urandom;
                q.clr = ($urandom_range(0, 15) == 0);
                if (n == 0) r0 = q; else r1 = q;
            end
            cyc(r0, r1);
        end
        cyc(z, z);

        for (int i = 0; i < 16; i++) chk($sformatf("ram[%0d]", i), ram[i], gmem[i]);
        chk("ram[last]", ram[DEPTH-1], gmem[DEPTH-1]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
